// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - breakpoint/IR/keyboard interrupt controller with single-level service FSM
module int_ctrl (
  input  logic        clk,
  input  logic        rstN,
  input  logic [31:0] pc,
  input  logic        pcValid,
  input  logic [31:0] bp0Addr,
  input  logic [31:0] bp1Addr,
  input  logic [31:0] bp2Addr,
  input  logic [31:0] bp3Addr,
  input  logic        bp0En,
  input  logic        bp1En,
  input  logic        bp2En,
  input  logic        bp3En,
  input  logic [31:0] bpAddr,
  input  logic [31:0] irAddr,
  input  logic [31:0] keyboardAddr,
  input  logic        irEn,
  input  logic        keyboardEn,
  input  logic        irEvent,
  input  logic        kbEvent,
  input  logic        intAck,
  input  logic        intDone,
  output logic        intReq,
  output logic [31:0] intVector,
  output logic [2:0]  intSource,
  output logic [1:0]  overrun,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  localparam logic [2:0] SRC_NONE = 3'd0;
  localparam logic [2:0] SRC_IR   = 3'd5;
  localparam logic [2:0] SRC_KB   = 3'd6;

  state_t     state;
  logic       bp_pend;
  logic [1:0] bp_idx;
  logic       ir_pend;
  logic       kb_pend;

  logic [3:0] bp_en_vec;
  logic [3:0] bp_match;
  logic [1:0] bp_hit_idx;
  logic       bp_elig;
  logic       ir_elig;
  logic       kb_elig;
  logic       ack_now;
  logic       bp_ack;
  logic       ir_ack;
  logic       kb_ack;

  assign bp_en_vec = {bp3En, bp2En, bp1En, bp0En};
  assign bp_match  = {bp3En && (pc == bp3Addr),
                      bp2En && (pc == bp2Addr),
                      bp1En && (pc == bp1Addr),
                      bp0En && (pc == bp0Addr)};

  // Lowest matching breakpoint index wins (later assignments override earlier ones)
  always_comb begin
    bp_hit_idx = 2'd0;
    if (bp_match[3]) bp_hit_idx = 2'd3;
    if (bp_match[2]) bp_hit_idx = 2'd2;
    if (bp_match[1]) bp_hit_idx = 2'd1;
    if (bp_match[0]) bp_hit_idx = 2'd0;
  end

  // A masked source stays pending; it only competes while its enable is high
  assign bp_elig = bp_pend && bp_en_vec[bp_idx];
  assign ir_elig = ir_pend && irEn;
  assign kb_elig = kb_pend && keyboardEn;

  // The latched intSource identifies which pending flag the acknowledge retires
  assign ack_now = (state == REQ) && intAck;
  assign bp_ack  = ack_now && (intSource != SRC_NONE) && (intSource < SRC_IR);
  assign ir_ack  = ack_now && (intSource == SRC_IR);
  assign kb_ack  = ack_now && (intSource == SRC_KB);

  assign busy = (state != IDLE);

  // Pending/overrun bookkeeping plus the IDLE -> REQ -> SERVICE sequencer
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      bp_pend   <= 1'b0;
      bp_idx    <= 2'd0;
      ir_pend   <= 1'b0;
      kb_pend   <= 1'b0;
      overrun   <= 2'b00;
      intReq    <= 1'b0;
      intVector <= 32'd0;
      intSource <= SRC_NONE;
    end else begin
      // An event arriving with its own acknowledge re-arms the flag without counting as lost
      if (ir_ack) begin
        ir_pend    <= irEvent;
        overrun[0] <= 1'b0;
      end else if (irEvent) begin
        ir_pend <= 1'b1;
        if (ir_pend) overrun[0] <= 1'b1;
      end

      if (kb_ack) begin
        kb_pend    <= kbEvent;
        overrun[1] <= 1'b0;
      end else if (kbEvent) begin
        kb_pend <= 1'b1;
        if (kb_pend) overrun[1] <= 1'b1;
      end

      // Breakpoints are only captured while idle, keeping the first recorded hit
      if (bp_ack) begin
        bp_pend <= 1'b0;
      end else if ((state == IDLE) && pcValid && (|bp_match) && !bp_pend) begin
        bp_pend <= 1'b1;
        bp_idx  <= bp_hit_idx;
      end

      case (state)
        IDLE: begin
          if (bp_elig) begin
            state     <= REQ;
            intReq    <= 1'b1;
            intVector <= bpAddr;
            intSource <= 3'd1 + {1'b0, bp_idx};
          end else if (ir_elig) begin
            state     <= REQ;
            intReq    <= 1'b1;
            intVector <= irAddr;
            intSource <= SRC_IR;
          end else if (kb_elig) begin
            state     <= REQ;
            intReq    <= 1'b1;
            intVector <= keyboardAddr;
            intSource <= SRC_KB;
          end
        end
        REQ: begin
          if (intAck) begin
            state  <= SERVICE;
            intReq <= 1'b0;
          end
        end
        SERVICE: begin
          if (intDone) begin
            state     <= IDLE;
            intSource <= SRC_NONE;
          end
        end
        default: begin
          state  <= IDLE;
          intReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed self-checking bench for int_ctrl
module tb_int_ctrl;

  logic        clk;
  logic        rstN;
  logic [31:0] pc;
  logic        pcValid;
  logic [31:0] bp0Addr, bp1Addr, bp2Addr, bp3Addr;
  logic        bp0En, bp1En, bp2En, bp3En;
  logic [31:0] bpAddr, irAddr, keyboardAddr;
  logic        irEn, keyboardEn;
  logic        irEvent, kbEvent;
  logic        intAck, intDone;
  logic        intReq;
  logic [31:0] intVector;
  logic [2:0]  intSource;
  logic [1:0]  overrun;
  logic        busy;

  int tests_run;
  int fail_count;

  int_ctrl dut (
    .clk(clk), .rstN(rstN), .pc(pc), .pcValid(pcValid),
    .bp0Addr(bp0Addr), .bp1Addr(bp1Addr), .bp2Addr(bp2Addr), .bp3Addr(bp3Addr),
    .bp0En(bp0En), .bp1En(bp1En), .bp2En(bp2En), .bp3En(bp3En),
    .bpAddr(bpAddr), .irAddr(irAddr), .keyboardAddr(keyboardAddr),
    .irEn(irEn), .keyboardEn(keyboardEn), .irEvent(irEvent), .kbEvent(kbEvent),
    .intAck(intAck), .intDone(intDone), .intReq(intReq), .intVector(intVector),
    .intSource(intSource), .overrun(overrun), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_and_done();
    intAck = 1'b1;
    step();
    intAck  = 1'b0;
    intDone = 1'b1;
    step();
    intDone = 1'b0;
  endtask

  task automatic pulse_ir();
    irEvent = 1'b1;
    step();
    irEvent = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    fail_count = 0;
    rstN = 1'b0; pc = 32'd0; pcValid = 1'b0;
    bp0Addr = 32'd0; bp1Addr = 32'd0; bp2Addr = 32'd0; bp3Addr = 32'd0;
    bp0En = 1'b0; bp1En = 1'b0; bp2En = 1'b0; bp3En = 1'b0;
    bpAddr = 32'd0; irAddr = 32'd0; keyboardAddr = 32'd0;
    irEn = 1'b0; keyboardEn = 1'b0; irEvent = 1'b0; kbEvent = 1'b0;
    intAck = 1'b0; intDone = 1'b0;

    // reset state
    step(); step();
    check("rst_req", 32'(intReq), 32'd0);
    check("rst_vec", intVector, 32'd0);
    check("rst_src", 32'(intSource), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rstN = 1'b1;
    step();

    // IR request, ack, done
    irEn = 1'b1; irAddr = 32'h0000_1200;
    pulse_ir();
    check("ir_lat_e", 32'(intReq), 32'd0);
    step();
    check("ir_req", 32'(intReq), 32'd1);
    check("ir_vec", intVector, 32'h0000_1200);
    check("ir_src", 32'(intSource), 32'd5);
    check("ir_busy_req", 32'(busy), 32'd1);
    intAck = 1'b1; step(); intAck = 1'b0;
    check("ir_ack_req", 32'(intReq), 32'd0);
    check("ir_ack_busy", 32'(busy), 32'd1);
    check("ir_ack_src", 32'(intSource), 32'd5);
    intDone = 1'b1; step(); intDone = 1'b0;
    check("ir_done_busy", 32'(busy), 32'd0);
    check("ir_done_src", 32'(intSource), 32'd0);
    check("ir_done_vec", intVector, 32'h0000_1200);
    step();
    check("ir_no_rereq", 32'(intReq), 32'd0);

    // breakpoint beats simultaneous keyboard; lowest matching index recorded
    keyboardEn = 1'b1; keyboardAddr = 32'h0000_2000;
    bp2En = 1'b1; bp2Addr = 32'h40; bp3En = 1'b1; bp3Addr = 32'h40; bpAddr = 32'h300;
    pc = 32'h40; pcValid = 1'b1; kbEvent = 1'b1;
    step();
    pcValid = 1'b0; kbEvent = 1'b0;
    step();
    check("bp_src", 32'(intSource), 32'd3);
    check("bp_vec", intVector, 32'h300);
    ack_and_done();
    check("bp_done_src", 32'(intSource), 32'd0);
    check("bp_done_req", 32'(intReq), 32'd0);
    step();
    check("kb_after_bp_req", 32'(intReq), 32'd1);
    check("kb_after_bp_src", 32'(intSource), 32'd6);
    check("kb_after_bp_vec", intVector, 32'h0000_2000);
    ack_and_done();
    bp2En = 1'b0; bp3En = 1'b0;

    // masked keyboard stays pending until enabled
    keyboardEn = 1'b0;
    kbEvent = 1'b1; step(); kbEvent = 1'b0;
    step(); step();
    check("kb_masked", 32'(intReq), 32'd0);
    keyboardEn = 1'b1;
    step(); step();
    check("kb_unmask_req", 32'(intReq), 32'd1);
    check("kb_unmask_src", 32'(intSource), 32'd6);
    ack_and_done();

    // IR beats keyboard
    irEvent = 1'b1; kbEvent = 1'b1; step(); irEvent = 1'b0; kbEvent = 1'b0;
    step();
    check("prio_ir_src", 32'(intSource), 32'd5);
    ack_and_done();
    step();
    check("prio_kb_src", 32'(intSource), 32'd6);
    ack_and_done();

    // IR overrun, enable drop does not withdraw, ack clears overrun and pend
    pulse_ir();
    step();
    pulse_ir();
    check("ovr_set", 32'(overrun), 32'd1);
    irEn = 1'b0; step();
    check("ovr_hold_req", 32'(intReq), 32'd1);
    check("ovr_hold_src", 32'(intSource), 32'd5);
    irEn = 1'b1;
    intAck = 1'b1; step(); intAck = 1'b0;
    check("ovr_clr", 32'(overrun), 32'd0);
    intDone = 1'b1; step(); intDone = 1'b0;
    step(); step();
    check("ovr_pend_clr", 32'(intReq), 32'd0);

    // event together with its own ack stays pending, no overrun
    pulse_ir(); step();
    intAck = 1'b1; irEvent = 1'b1; step(); intAck = 1'b0; irEvent = 1'b0;
    check("ackev_ovr", 32'(overrun), 32'd0);
    intDone = 1'b1; step(); intDone = 1'b0;
    step();
    check("ackev_rereq", 32'(intReq), 32'd1);
    check("ackev_src", 32'(intSource), 32'd5);

    // reset mid-REQ abandons the request asynchronously
    rstN = 1'b0;
    #1;
    check("midrst_req", 32'(intReq), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    step();
    rstN = 1'b1;
    step(); step();
    check("midrst_after", 32'(intReq), 32'd0);

    // breakpoint match during SERVICE is ignored
    pulse_ir(); step();
    intAck = 1'b1; step(); intAck = 1'b0;
    bp0En = 1'b1; bp0Addr = 32'h80; pc = 32'h80; pcValid = 1'b1;
    step();
    pcValid = 1'b0;
    intDone = 1'b1; step(); intDone = 1'b0;
    step(); step();
    check("svc_bp_ignored", 32'(intReq), 32'd0);
    check("svc_bp_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
